// File: rtl/nbit_seq_multiplier_pkg.sv
// rtl/nbit_seq_multiplier_pkg.sv - shared types and adder helper for the sequential multiplier
package mult_pkg;

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, HOLD} mult_state_t;

  localparam int MAX_WIDTH = 32;

  // WIDTH+1-bit add/subtract; bit [width] is the carry (unsigned) or the sign (signed)
  function automatic logic [MAX_WIDTH:0] add_sub(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] s,
    input int                   width,
    input logic                 signed_mode,
    input logic                 sub
  );
    logic [MAX_WIDTH:0] ext_mask;
    logic [MAX_WIDTH:0] ea;
    logic [MAX_WIDTH:0] es;
    logic [4:0]         msb;
    ext_mask = {(MAX_WIDTH+1){1'b1}} << width;
    msb      = 5'(width - 1);
    ea       = {1'b0, a};
    es       = {1'b0, s};
    if (signed_mode && a[msb]) ea = ea | ext_mask;
    if (signed_mode && s[msb]) es = es | ext_mask;
    return sub ? (ea - es) : (ea + es);
  endfunction

endpackage

// File: rtl/nbit_seq_multiplier_if.sv
// rtl/nbit_seq_multiplier_if.sv - control/operand/result bundle of the sequential multiplier
interface nbit_seq_multiplier_if #(parameter int WIDTH = 8);

  logic             Run;
  logic             ClearA_LoadB;
  logic             Signed_Mode;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic             X;
  logic             Busy;
  logic             Done;

  modport master (
    output Run, ClearA_LoadB, Signed_Mode, S,
    input  Aval, Bval, X, Busy, Done
  );

  modport slave (
    input  Run, ClearA_LoadB, Signed_Mode, S,
    output Aval, Bval, X, Busy, Done
  );

endinterface

// File: rtl/nbit_seq_multiplier_fsm.sv
// rtl/nbit_seq_multiplier_fsm.sv - sequencing FSM: state, bit count, mode latch and datapath strobes
module seq_mult_fsm
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear_load,
  input  logic signed_mode,
  input  logic b_lsb,
  output logic busy,
  output logic done,
  output logic mode,
  output logic load_en,
  output logic start_en,
  output logic add_en,
  output logic sub_en,
  output logic shift_en
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t   state;
  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      mode  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!clear_load && run) begin
            state <= ADD;
            count <= '0;
            mode  <= signed_mode;
            busy  <= 1'b1;
          end
        end
        ADD: state <= SHIFT;
        SHIFT: begin
          count <= count + CW'(1);
          if (count == LAST) begin
            state <= HOLD;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= ADD;
          end
        end
        HOLD: begin
          // Wait for Run to drop so a held Run cannot retrigger
          if (!run) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign load_en  = (state == IDLE) && clear_load;
  assign start_en = (state == IDLE) && !clear_load && run;
  assign add_en   = (state == ADD) && b_lsb;
  assign sub_en   = mode && (count == LAST);
  assign shift_en = (state == SHIFT);

endmodule

// File: rtl/nbit_seq_multiplier.sv
// rtl/nbit_seq_multiplier.sv - shift-add multiplier datapath; product ends in {Aval,Bval}, X above A
module nbit_seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  nbit_seq_multiplier_if.slave  bus
);

  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               x_reg;
  logic               busy;
  logic               done;
  logic               mode;
  logic               load_en;
  logic               start_en;
  logic               add_en;
  logic               sub_en;
  logic               shift_en;
  logic [MAX_WIDTH:0] sum_full;
  logic               unused_sum;

  seq_mult_fsm #(.WIDTH(WIDTH)) u_fsm (
    .clk         (Clk),
    .rst         (Reset),
    .run         (bus.Run),
    .clear_load  (bus.ClearA_LoadB),
    .signed_mode (bus.Signed_Mode),
    .b_lsb       (b_reg[0]),
    .busy        (busy),
    .done        (done),
    .mode        (mode),
    .load_en     (load_en),
    .start_en    (start_en),
    .add_en      (add_en),
    .sub_en      (sub_en),
    .shift_en    (shift_en)
  );

  assign sum_full   = add_sub(MAX_WIDTH'(a_reg), MAX_WIDTH'(bus.S), WIDTH, mode, sub_en);
  assign unused_sum = ^sum_full;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_reg <= '0;
      b_reg <= '0;
      x_reg <= 1'b0;
    end else if (load_en) begin
      a_reg <= '0;
      b_reg <= bus.S;
      x_reg <= 1'b0;
    end else if (start_en) begin
      a_reg <= '0;
      x_reg <= 1'b0;
    end else if (add_en) begin
      {x_reg, a_reg} <= sum_full[WIDTH:0];
    end else if (shift_en) begin
      // X is held in signed mode so the shift is arithmetic
      b_reg <= {a_reg[0], b_reg[WIDTH-1:1]};
      a_reg <= {x_reg, a_reg[WIDTH-1:1]};
      if (!mode) x_reg <= 1'b0;
    end
  end

  assign bus.Aval = a_reg;
  assign bus.Bval = b_reg;
  assign bus.X    = x_reg;
  assign bus.Busy = busy;
  assign bus.Done = done;

endmodule

// File: tb/tb_nbit_seq_multiplier.sv
// tb/tb_nbit_seq_multiplier.sv - self-checking bench for nbit_seq_multiplier at WIDTH 4, 8 and 16
module tb_nbit_seq_multiplier;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        x;
  } exp_t;

  typedef struct {
    logic        sm;
    logic [31:0] b;
    logic [31:0] s;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ex;
  } vec_t;

  logic        Clk = 1'b0;
  logic        rst_all;
  logic        d_rst;
  logic        d_run;
  logic        d_clr;
  logic        d_sm;
  logic [31:0] d_s;
  int          cur_w;
  logic        rst4, rst8, rst16;

  logic [31:0] v_a, v_b;
  logic        v_x, v_busy, v_done;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] model_b;
  vec_t        vecs[8];

  always #5 Clk = ~Clk;

  nbit_seq_multiplier_if #(.WIDTH(4))  bus4();
  nbit_seq_multiplier_if #(.WIDTH(8))  bus8();
  nbit_seq_multiplier_if #(.WIDTH(16)) bus16();

  nbit_seq_multiplier #(.WIDTH(4))  dut4  (.Clk(Clk), .Reset(rst4),  .bus(bus4));
  nbit_seq_multiplier #(.WIDTH(8))  dut8  (.Clk(Clk), .Reset(rst8),  .bus(bus8));
  nbit_seq_multiplier #(.WIDTH(16)) dut16 (.Clk(Clk), .Reset(rst16), .bus(bus16));

  assign rst4  = rst_all || (d_rst && cur_w == 4);
  assign rst8  = rst_all || (d_rst && cur_w == 8);
  assign rst16 = rst_all || (d_rst && cur_w == 16);

  assign bus4.Run           = d_run && cur_w == 4;
  assign bus4.ClearA_LoadB  = d_clr && cur_w == 4;
  assign bus4.Signed_Mode   = d_sm && cur_w == 4;
  assign bus4.S             = (cur_w == 4) ? d_s[3:0] : 4'h0;
  assign bus8.Run           = d_run && cur_w == 8;
  assign bus8.ClearA_LoadB  = d_clr && cur_w == 8;
  assign bus8.Signed_Mode   = d_sm && cur_w == 8;
  assign bus8.S             = (cur_w == 8) ? d_s[7:0] : 8'h0;
  assign bus16.Run          = d_run && cur_w == 16;
  assign bus16.ClearA_LoadB = d_clr && cur_w == 16;
  assign bus16.Signed_Mode  = d_sm && cur_w == 16;
  assign bus16.S            = (cur_w == 16) ? d_s[15:0] : 16'h0;

  always_comb begin
    v_a = 32'h0; v_b = 32'h0; v_x = 1'b0; v_busy = 1'b0; v_done = 1'b0;
    case (cur_w)
      4: begin
        v_a = 32'(bus4.Aval); v_b = 32'(bus4.Bval); v_x = bus4.X;
        v_busy = bus4.Busy; v_done = bus4.Done;
      end
      16: begin
        v_a = 32'(bus16.Aval); v_b = 32'(bus16.Bval); v_x = bus16.X;
        v_busy = bus16.Busy; v_done = bus16.Done;
      end
      default: begin
        v_a = 32'(bus8.Aval); v_b = 32'(bus8.Bval); v_x = bus8.X;
        v_busy = bus8.Busy; v_done = bus8.Done;
      end
    endcase
  end

  function automatic logic [31:0] wmask(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic exp_t ref_mul(input int w, input logic sm, input logic [31:0] b,
                                   input logic [31:0] s);
    logic [63:0] m, pb, ps, p;
    exp_t r;
    m  = (64'd1 << w) - 64'd1;
    pb = {32'h0, b} & m;
    ps = {32'h0, s} & m;
    if (sm && pb[w-1]) pb = pb | ~m;
    if (sm && ps[w-1]) ps = ps | ~m;
    p   = pb * ps;
    r.a = 32'((p >> w) & m);
    r.b = 32'(p & m);
    r.x = sm ? p[2*w-1] : 1'b0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s w=%0d actual=%0h required=%0h", name, cur_w, act, req);
    end
  endtask

  task automatic load_b(input logic [31:0] b);
    @(negedge Clk);
    d_clr = 1'b1;
    d_s   = b & wmask(cur_w);
    @(negedge Clk);
    d_clr = 1'b0;
    model_b = b & wmask(cur_w);
    chk("load_b", v_b, model_b);
  endtask

  // clr_at >= 0 pulses ClearA_LoadB on that sample while the operation is running
  task automatic run_op(input logic sm, input logic [31:0] s, input exp_t e,
                        input int hold, input int clr_at);
    int   cycles;
    int   bcnt;
    logic prev_busy;
    exp_t got;
    sb.push_back(e);
    @(negedge Clk);
    d_sm  = sm;
    d_s   = s & wmask(cur_w);
    d_run = 1'b1;
    cycles = 0; bcnt = 0; prev_busy = 1'b0;
    while (cycles < 200) begin
      @(negedge Clk);
      d_clr = (cycles == clr_at);
      cycles++;
      if (v_busy) bcnt++;
      if (v_done) break;
      prev_busy = v_busy;
    end
    d_clr = 1'b0;
    got = sb.pop_front();
    if (!v_done) begin
      chk("done_timeout", 32'(v_done), 32'd1);
    end else begin
      chk("prod_a", v_a, got.a);
      chk("prod_b", v_b, got.b);
      chk("prod_x", 32'(v_x), 32'(got.x));
      chk("busy_len", 32'(bcnt), 32'(2 * cur_w));
      chk("done_edge", {30'h0, prev_busy, v_busy}, 32'h2);
    end
    model_b = got.b;
    repeat (hold) begin
      @(negedge Clk);
      chk("done_hold", {30'h0, v_done, v_busy}, 32'h2);
    end
    d_run = 1'b0;
    @(negedge Clk);
    chk("done_clear", 32'(v_done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog w=%0d actual=timeout required=finish", cur_w);
    $fatal(1);
  end

  initial begin
    int          cnt;
    int          guard;
    logic [31:0] rb, rs;
    logic        rsm;
    int          widths[2];

    vecs[0] = '{1'b1, 32'h07, 32'hFD, 32'hFF, 32'hEB, 1'b1};
    vecs[1] = '{1'b1, 32'h80, 32'h80, 32'h40, 32'h00, 1'b0};
    vecs[2] = '{1'b0, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0};
    vecs[3] = '{1'b1, 32'h7F, 32'h7F, 32'h3F, 32'h01, 1'b0};
    vecs[4] = '{1'b1, 32'h01, 32'h80, 32'hFF, 32'h80, 1'b1};
    vecs[5] = '{1'b0, 32'h80, 32'hFF, 32'h7F, 32'h80, 1'b0};
    vecs[6] = '{1'b0, 32'h00, 32'h55, 32'h00, 32'h00, 1'b0};
    vecs[7] = '{1'b1, 32'hFF, 32'h01, 32'hFF, 32'hFF, 1'b1};

    d_run = 1'b0; d_clr = 1'b0; d_sm = 1'b0; d_s = 32'h0; d_rst = 1'b0;
    cur_w = 8; model_b = 32'h0;
    rst_all = 1'b1;
    repeat (2) @(negedge Clk);
    rst_all = 1'b0;

    widths[0] = 4; widths[1] = 16;
    for (int k = 0; k < 3; k++) begin
      cur_w = (k == 0) ? 4 : (k == 1) ? 8 : 16;
      @(negedge Clk);
      chk("rst_a", v_a, 32'h0);
      chk("rst_b", v_b, 32'h0);
      chk("rst_flags", {29'h0, v_x, v_busy, v_done}, 32'h0);
    end

    cur_w = 8;
    for (int i = 0; i < 8; i++) begin
      load_b(vecs[i].b);
      run_op(vecs[i].sm, vecs[i].s, '{vecs[i].ea, vecs[i].eb, vecs[i].ex}, 0, -1);
    end

    load_b(32'h02);
    run_op(1'b0, 32'h03, '{32'h00, 32'h06, 1'b0}, 5, -1);
    run_op(1'b0, 32'h03, '{32'h00, 32'h12, 1'b0}, 0, -1);

    load_b(32'h07);
    @(negedge Clk);
    d_sm = 1'b1; d_s = 32'hFD; d_run = 1'b1;
    cnt = 0; guard = 0;
    while (cnt < 5 && guard < 100) begin
      @(negedge Clk);
      guard++;
      if (v_busy) cnt++;
    end
    chk("busy_before_rst", 32'(v_busy), 32'd1);
    #2;
    d_rst = 1'b1;
    d_run = 1'b0;
    #1;
    chk("midrst_a", v_a, 32'h0);
    chk("midrst_b", v_b, 32'h0);
    chk("midrst_flags", {29'h0, v_x, v_busy, v_done}, 32'h0);
    @(negedge Clk);
    d_rst = 1'b0;
    repeat (3) @(negedge Clk);
    chk("post_rst_idle", {30'h0, v_busy, v_done}, 32'h0);
    model_b = 32'h0;

    load_b(32'h07);
    run_op(1'b1, 32'hFD, '{32'hFF, 32'hEB, 1'b1}, 0, 5);

    for (int i = 0; i < 4; i++) begin
      rb = $urandom; rs = $urandom; rsm = 1'($urandom_range(0, 1));
      if (i != 2) load_b(rb);
      run_op(rsm, rs, ref_mul(8, rsm, model_b, rs), 0, -1);
    end

    for (int k = 0; k < 2; k++) begin
      cur_w = widths[k];
      @(negedge Clk);
      load_b(32'h1 << (cur_w - 1));
      rs = 32'h1 << (cur_w - 1);
      run_op(1'b1, rs, ref_mul(cur_w, 1'b1, model_b, rs), 0, -1);
      load_b(wmask(cur_w));
      run_op(1'b0, wmask(cur_w), ref_mul(cur_w, 1'b0, model_b, wmask(cur_w)), 0, -1);
      for (int i = 0; i < 10; i++) begin
        rb = $urandom; rs = $urandom; rsm = 1'($urandom_range(0, 1));
        if (i % 3 != 2) load_b(rb);
        run_op(rsm, rs, ref_mul(cur_w, rsm, model_b, rs), 0, -1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
